// File: rtl/lsb_queue.sv
// lsb_queue: in-order load/store queue between dispatch, the CDB result buses and a
// single-request memory port.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   i_rdy                 clock enable; low holds every register (state and outputs)
//   i_flush               mispredict flush; keeps only the committed-store prefix
//   i_disp_*              dispatch request (op kind, size, sign, tag, imm, operands)
//   o_disp_ready          queue not full (combinational from count)
//   i_cdb_valid/tag/data  CDB_CH snooped result buses, channel 0 in the LSBs
//   i_commit_valid/tag    ROB head commit; marks the matching store committed
//   o_mem_*               one registered memory request, held until i_mem_done
//   i_mem_done/rdata      completion pulse and raw load data
//   o_res_valid/tag/data  one-cycle load result pulse
module lsb_queue #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned CDB_CH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_rdy,
    input  logic                     i_flush,
    input  logic                     i_disp_valid,
    output logic                     o_disp_ready,
    input  logic                     i_disp_is_store,
    input  logic [1:0]               i_disp_size,
    input  logic                     i_disp_signed,
    input  logic [TAG_W-1:0]         i_disp_tag,
    input  logic [31:0]              i_disp_imm,
    input  logic                     i_disp_base_rdy,
    input  logic [31:0]              i_disp_base_val,
    input  logic [TAG_W-1:0]         i_disp_base_q,
    input  logic                     i_disp_data_rdy,
    input  logic [31:0]              i_disp_data_val,
    input  logic [TAG_W-1:0]         i_disp_data_q,
    input  logic [CDB_CH-1:0]        i_cdb_valid,
    input  logic [CDB_CH*TAG_W-1:0]  i_cdb_tag,
    input  logic [CDB_CH*32-1:0]     i_cdb_data,
    input  logic                     i_commit_valid,
    input  logic [TAG_W-1:0]         i_commit_tag,
    output logic                     o_mem_req,
    output logic                     o_mem_we,
    output logic [31:0]              o_mem_addr,
    output logic [31:0]              o_mem_wdata,
    output logic [1:0]               o_mem_size,
    input  logic                     i_mem_done,
    input  logic [31:0]              i_mem_rdata,
    output logic                     o_res_valid,
    output logic [TAG_W-1:0]         o_res_tag,
    output logic [31:0]              o_res_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {StIdle, StLoad, StStore, StDrain} state_e;

    // Entry storage
    logic             r_is_store  [DEPTH];
    logic [1:0]       r_size      [DEPTH];
    logic             r_signed    [DEPTH];
    logic [TAG_W-1:0] r_tag       [DEPTH];
    logic [31:0]      r_imm       [DEPTH];
    logic             r_base_rdy  [DEPTH];
    logic [31:0]      r_base_val  [DEPTH];
    logic [TAG_W-1:0] r_base_q    [DEPTH];
    logic             r_data_rdy  [DEPTH];
    logic [31:0]      r_data_val  [DEPTH];
    logic [TAG_W-1:0] r_data_q    [DEPTH];
    logic             r_committed [DEPTH];

    logic [PTR_W-1:0] r_head, r_tail;
    logic [CNT_W-1:0] r_count;
    state_e           r_state;

    logic             r_mem_req, r_mem_we;
    logic [31:0]      r_mem_addr, r_mem_wdata;
    logic [1:0]       r_mem_size;
    logic             r_res_valid;
    logic [TAG_W-1:0] r_res_tag;
    logic [31:0]      r_res_data;

    // Next-state and decode wires
    state_e           w_state_nxt;
    logic [PTR_W-1:0] w_head_nxt, w_tail_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic [CNT_W-1:0] w_keep_cnt;
    logic             w_disp_fire;
    logic             w_head_ready;
    logic             w_issue, w_pop, w_res_fire;
    logic [DEPTH-1:0] w_slot_valid, w_commit_hit;
    logic [DEPTH-1:0] w_base_hit, w_data_hit;
    logic [31:0]      w_base_cap [DEPTH];
    logic [31:0]      w_data_cap [DEPTH];
    logic             w_disp_base_hit, w_disp_data_hit;
    logic [31:0]      w_disp_base_cap, w_disp_data_cap;

    // Returns {hit, data}; channels scanned high to low so the lowest matching index wins.
    function automatic logic [32:0] cdb_lookup(
        input logic [TAG_W-1:0]        q,
        input logic [CDB_CH-1:0]       valid,
        input logic [CDB_CH*TAG_W-1:0] tags,
        input logic [CDB_CH*32-1:0]    data
    );
        logic [32:0] hit;
        hit = '0;
        for (int c = int'(CDB_CH) - 1; c >= 0; c--) begin
            if (valid[c] && (tags[c*TAG_W +: TAG_W] == q)) begin
                hit = {1'b1, data[c*32 +: 32]};
            end
        end
        return hit;
    endfunction

    function automatic logic [31:0] extend(
        input logic [1:0]  size,
        input logic        sgn,
        input logic [31:0] raw
    );
        logic [31:0] res;
        case (size)
            2'd0:    res = {{24{sgn & raw[7]}}, raw[7:0]};
            2'd1:    res = {{16{sgn & raw[15]}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    assign o_disp_ready = (r_count < CNT_W'(DEPTH));
    assign w_disp_fire  = i_disp_valid && o_disp_ready && !i_flush;

    assign w_head_ready = (r_count != '0) && r_base_rdy[r_head] &&
                          (!r_is_store[r_head] || (r_data_rdy[r_head] && r_committed[r_head]));

    // Per-slot validity, snoop matches and commit matches
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_slot_valid[i] = ({1'b0, PTR_W'(i) - r_head} < r_count);
            w_commit_hit[i] = i_commit_valid && w_slot_valid[i] && r_is_store[i] &&
                              (r_tag[i] == i_commit_tag);
            {w_base_hit[i], w_base_cap[i]} = cdb_lookup(r_base_q[i], i_cdb_valid, i_cdb_tag,
                                                        i_cdb_data);
            {w_data_hit[i], w_data_cap[i]} = cdb_lookup(r_data_q[i], i_cdb_valid, i_cdb_tag,
                                                        i_cdb_data);
        end
        {w_disp_base_hit, w_disp_base_cap} = cdb_lookup(i_disp_base_q, i_cdb_valid, i_cdb_tag,
                                                        i_cdb_data);
        {w_disp_data_hit, w_disp_data_cap} = cdb_lookup(i_disp_data_q, i_cdb_valid, i_cdb_tag,
                                                        i_cdb_data);
    end

    // Length of the committed-store run starting at head, with this cycle's commit applied,
    // so a commit arriving together with a flush keeps its store.
    always_comb begin
        logic             run;
        logic [PTR_W-1:0] idx;
        w_keep_cnt = '0;
        run        = 1'b1;
        idx        = r_head;
        for (int k = 0; k < int'(DEPTH); k++) begin
            idx = r_head + PTR_W'(k);
            if (run && (CNT_W'(k) < r_count) && (r_committed[idx] || w_commit_hit[idx])) begin
                w_keep_cnt = w_keep_cnt + CNT_W'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    // Memory FSM: next state and control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_pop       = 1'b0;
        w_res_fire  = 1'b0;
        case (r_state)
            StIdle: begin
                // Defer issue by a cycle on flush; a surviving store issues next cycle.
                if (w_head_ready && !i_flush) begin
                    w_issue     = 1'b1;
                    w_state_nxt = r_is_store[r_head] ? StStore : StLoad;
                end
            end
            StLoad: begin
                if (i_mem_done) begin
                    w_state_nxt = StIdle;
                    // A flush in the completion cycle drops the load and its result.
                    if (!i_flush) begin
                        w_pop      = 1'b1;
                        w_res_fire = 1'b1;
                    end
                end else if (i_flush) begin
                    w_state_nxt = StDrain;
                end
            end
            StStore: begin
                if (i_mem_done) begin
                    w_pop       = 1'b1;
                    w_state_nxt = StIdle;
                end
            end
            StDrain: begin
                if (i_mem_done) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // Pointer and occupancy update
    always_comb begin
        w_head_nxt  = r_head + PTR_W'(w_pop);
        w_tail_nxt  = r_tail;
        w_count_nxt = r_count;
        if (i_flush) begin
            // Only a committed store can pop here, so it is part of the kept run.
            w_tail_nxt  = r_head + w_keep_cnt[PTR_W-1:0];
            w_count_nxt = w_keep_cnt - CNT_W'(w_pop);
        end else begin
            w_tail_nxt  = r_tail + PTR_W'(w_disp_fire);
            w_count_nxt = r_count + CNT_W'(w_disp_fire) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_rdy) begin
            r_state <= w_state_nxt;
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Entry updates: snoop, commit, then dispatch write (tail slot is never live when written)
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_base_rdy[i]  <= 1'b0;
                r_data_rdy[i]  <= 1'b0;
                r_committed[i] <= 1'b0;
            end
        end else if (i_rdy) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (!r_base_rdy[i] && w_base_hit[i]) begin
                    r_base_rdy[i] <= 1'b1;
                    r_base_val[i] <= w_base_cap[i];
                end
                if (!r_data_rdy[i] && w_data_hit[i]) begin
                    r_data_rdy[i] <= 1'b1;
                    r_data_val[i] <= w_data_cap[i];
                end
                if (w_commit_hit[i]) begin
                    r_committed[i] <= 1'b1;
                end
            end
            if (w_disp_fire) begin
                r_is_store[r_tail]  <= i_disp_is_store;
                r_size[r_tail]      <= i_disp_size;
                r_signed[r_tail]    <= i_disp_signed;
                r_tag[r_tail]       <= i_disp_tag;
                r_imm[r_tail]       <= i_disp_imm;
                r_committed[r_tail] <= 1'b0;
                r_base_q[r_tail]    <= i_disp_base_q;
                r_data_q[r_tail]    <= i_disp_data_q;
                r_base_rdy[r_tail]  <= i_disp_base_rdy || w_disp_base_hit;
                r_base_val[r_tail]  <= i_disp_base_rdy ? i_disp_base_val : w_disp_base_cap;
                r_data_rdy[r_tail]  <= i_disp_data_rdy || w_disp_data_hit;
                r_data_val[r_tail]  <= i_disp_data_rdy ? i_disp_data_val : w_disp_data_cap;
            end
        end
    end

    // Registered memory request and load result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_size  <= '0;
            r_res_valid <= 1'b0;
            r_res_tag   <= '0;
            r_res_data  <= '0;
        end else if (i_rdy) begin
            r_res_valid <= w_res_fire;
            if (w_res_fire) begin
                r_res_tag  <= r_tag[r_head];
                r_res_data <= extend(r_size[r_head], r_signed[r_head], i_mem_rdata);
            end
            if (w_issue) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= r_is_store[r_head];
                r_mem_addr  <= r_base_val[r_head] + r_imm[r_head];
                r_mem_wdata <= r_data_val[r_head];
                r_mem_size  <= r_size[r_head];
            end else if (i_mem_done && (r_state != StIdle)) begin
                r_mem_req <= 1'b0;
            end
        end
    end

    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_size  = r_mem_size;
    assign o_res_valid = r_res_valid;
    assign o_res_tag   = r_res_tag;
    assign o_res_data  = r_res_data;

endmodule

// File: tb/tb_lsb_queue.sv
// tb_lsb_queue: directed self-checking bench for lsb_queue (DEPTH=8, TAG_W=4, CDB_CH=2).
module tb_lsb_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_rdy = 1'b1;
    logic        i_flush = 1'b0;
    logic        i_disp_valid = 1'b0;
    logic        o_disp_ready;
    logic        i_disp_is_store = 1'b0;
    logic [1:0]  i_disp_size = 2'd0;
    logic        i_disp_signed = 1'b0;
    logic [3:0]  i_disp_tag = 4'd0;
    logic [31:0] i_disp_imm = 32'd0;
    logic        i_disp_base_rdy = 1'b0;
    logic [31:0] i_disp_base_val = 32'd0;
    logic [3:0]  i_disp_base_q = 4'd0;
    logic        i_disp_data_rdy = 1'b0;
    logic [31:0] i_disp_data_val = 32'd0;
    logic [3:0]  i_disp_data_q = 4'd0;
    logic [1:0]  i_cdb_valid = 2'b00;
    logic [7:0]  i_cdb_tag = 8'd0;
    logic [63:0] i_cdb_data = 64'd0;
    logic        i_commit_valid = 1'b0;
    logic [3:0]  i_commit_tag = 4'd0;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [1:0]  o_mem_size;
    logic        i_mem_done = 1'b0;
    logic [31:0] i_mem_rdata = 32'd0;
    logic        o_res_valid;
    logic [3:0]  o_res_tag;
    logic [31:0] o_res_data;

    int checks = 0;
    int errors = 0;

    lsb_queue #(.DEPTH(8), .TAG_W(4), .CDB_CH(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_rdy           (i_rdy),
        .i_flush         (i_flush),
        .i_disp_valid    (i_disp_valid),
        .o_disp_ready    (o_disp_ready),
        .i_disp_is_store (i_disp_is_store),
        .i_disp_size     (i_disp_size),
        .i_disp_signed   (i_disp_signed),
        .i_disp_tag      (i_disp_tag),
        .i_disp_imm      (i_disp_imm),
        .i_disp_base_rdy (i_disp_base_rdy),
        .i_disp_base_val (i_disp_base_val),
        .i_disp_base_q   (i_disp_base_q),
        .i_disp_data_rdy (i_disp_data_rdy),
        .i_disp_data_val (i_disp_data_val),
        .i_disp_data_q   (i_disp_data_q),
        .i_cdb_valid     (i_cdb_valid),
        .i_cdb_tag       (i_cdb_tag),
        .i_cdb_data      (i_cdb_data),
        .i_commit_valid  (i_commit_valid),
        .i_commit_tag    (i_commit_tag),
        .o_mem_req       (o_mem_req),
        .o_mem_we        (o_mem_we),
        .o_mem_addr      (o_mem_addr),
        .o_mem_wdata     (o_mem_wdata),
        .o_mem_size      (o_mem_size),
        .i_mem_done      (i_mem_done),
        .i_mem_rdata     (i_mem_rdata),
        .o_res_valid     (o_res_valid),
        .o_res_tag       (o_res_tag),
        .o_res_data      (o_res_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_disp(input logic st, input logic [1:0] sz, input logic sg,
                            input logic [3:0] tag, input logic [31:0] imm,
                            input logic brdy, input logic [31:0] bval, input logic [3:0] bq,
                            input logic drdy, input logic [31:0] dval, input logic [3:0] dq);
        i_disp_is_store = st;
        i_disp_size     = sz;
        i_disp_signed   = sg;
        i_disp_tag      = tag;
        i_disp_imm      = imm;
        i_disp_base_rdy = brdy;
        i_disp_base_val = bval;
        i_disp_base_q   = bq;
        i_disp_data_rdy = drdy;
        i_disp_data_val = dval;
        i_disp_data_q   = dq;
    endtask

    task automatic dispatch(input logic st, input logic [1:0] sz, input logic sg,
                            input logic [3:0] tag, input logic [31:0] imm,
                            input logic brdy, input logic [31:0] bval, input logic [3:0] bq,
                            input logic drdy, input logic [31:0] dval, input logic [3:0] dq);
        set_disp(st, sz, sg, tag, imm, brdy, bval, bq, drdy, dval, dq);
        i_disp_valid = 1'b1;
        tick();
        i_disp_valid = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 20) begin
            if (o_mem_req) ok = 1'b1;
            else begin
                tick();
                n++;
            end
        end
    endtask

    task automatic mem_complete(input logic [31:0] rd);
        i_mem_done  = 1'b1;
        i_mem_rdata = rd;
        tick();
        i_mem_done  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        checks++; if (o_disp_ready !== 1'b1) begin errors++;
            $display("FAIL reset_disp_ready: got %b want 1", o_disp_ready); end
        checks++; if (o_mem_req !== 1'b0) begin errors++;
            $display("FAIL reset_mem_req: got %b want 0", o_mem_req); end
        checks++; if (o_res_valid !== 1'b0) begin errors++;
            $display("FAIL reset_res_valid: got %b want 0", o_res_valid); end
        checks++; if ({o_mem_we, o_mem_addr, o_mem_wdata, o_mem_size} !== 67'd0) begin errors++;
            $display("FAIL reset_mem_bus: got addr %h wdata %h want 0", o_mem_addr, o_mem_wdata); end
        checks++; if ({o_res_tag, o_res_data} !== 36'd0) begin errors++;
            $display("FAIL reset_res_bus: got tag %h data %h want 0", o_res_tag, o_res_data); end
    endtask

    task automatic test_load_word();
        bit ok;
        dispatch(1'b0, 2'd2, 1'b0, 4'd5, 32'd4, 1'b1, 32'h100, 4'd0, 1'b0, 32'd0, 4'd0);
        wait_req(ok);
        checks++; if (!ok) begin errors++; $display("FAIL lw_req: mem_req=0 want 1"); end
        checks++; if (o_mem_addr !== 32'h104) begin errors++;
            $display("FAIL lw_addr: got %h want 00000104", o_mem_addr); end
        checks++; if (o_mem_we !== 1'b0 || o_mem_size !== 2'd2) begin errors++;
            $display("FAIL lw_we_size: got we %b size %0d want 0/2", o_mem_we, o_mem_size); end
        mem_complete(32'hDEADBEEF);
        checks++; if (o_res_valid !== 1'b1 || o_res_tag !== 4'd5) begin errors++;
            $display("FAIL lw_res_tag: got v %b tag %0d want 1/5", o_res_valid, o_res_tag); end
        checks++; if (o_res_data !== 32'hDEADBEEF) begin errors++;
            $display("FAIL lw_res_data: got %h want deadbeef", o_res_data); end
        checks++; if (o_mem_req !== 1'b0) begin errors++;
            $display("FAIL lw_req_drop: got %b want 0", o_mem_req); end
        tick();
        checks++; if (o_res_valid !== 1'b0) begin errors++;
            $display("FAIL lw_res_pulse: got %b want 0", o_res_valid); end
    endtask

    task automatic test_extension();
        bit          ok;
        logic [1:0]  sz  [5];
        logic        sg  [5];
        logic [31:0] rd  [5];
        logic [31:0] exp [5];
        sz  = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0};
        sg  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        rd  = '{32'h80, 32'h80, 32'h8001, 32'hFFFF8001, 32'h1234567F};
        exp = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001, 32'h0000007F};
        for (int i = 0; i < 5; i++) begin
            dispatch(1'b0, sz[i], sg[i], 4'(8 + i), 32'd0, 1'b1, 32'h700, 4'd0, 1'b0, 32'd0, 4'd0);
            wait_req(ok);
            checks++; if (!ok || o_mem_size !== sz[i]) begin errors++;
                $display("FAIL ext_req_%0d: req %b size %0d want 1/%0d", i, ok, o_mem_size, sz[i]); end
            mem_complete(rd[i]);
            checks++; if (o_res_valid !== 1'b1 || o_res_data !== exp[i]) begin errors++;
                $display("FAIL ext_data_%0d: got v %b %h want 1 %h", i, o_res_valid, o_res_data, exp[i]); end
        end
    endtask

    task automatic test_store_wait();
        bit ok;
        dispatch(1'b1, 2'd2, 1'b0, 4'd6, 32'd0, 1'b1, 32'h200, 4'd0, 1'b0, 32'd0, 4'd3);
        repeat (4) tick();
        checks++; if (o_mem_req !== 1'b0) begin errors++;
            $display("FAIL sw_wait_data: mem_req %b want 0", o_mem_req); end
        // Both channels carry tag 3; channel 0 must win.
        i_cdb_valid = 2'b11;
        i_cdb_tag   = {4'd3, 4'd3};
        i_cdb_data  = {32'h11111111, 32'hCAFEF00D};
        tick();
        i_cdb_valid = 2'b00;
        repeat (4) tick();
        checks++; if (o_mem_req !== 1'b0) begin errors++;
            $display("FAIL sw_wait_commit: mem_req %b want 0", o_mem_req); end
        i_commit_valid = 1'b1;
        i_commit_tag   = 4'd6;
        tick();
        i_commit_valid = 1'b0;
        wait_req(ok);
        checks++; if (!ok || o_mem_we !== 1'b1) begin errors++;
            $display("FAIL sw_req: req %b we %b want 1/1", ok, o_mem_we); end
        checks++; if (o_mem_wdata !== 32'hCAFEF00D || o_mem_addr !== 32'h200) begin errors++;
            $display("FAIL sw_data: got %h @%h want cafef00d @00000200", o_mem_wdata, o_mem_addr); end
        mem_complete(32'h0);
        checks++; if (o_res_valid !== 1'b0 || o_mem_req !== 1'b0) begin errors++;
            $display("FAIL sw_done: res_valid %b req %b want 0/0", o_res_valid, o_mem_req); end
    endtask

    task automatic test_cdb_dispatch();
        bit ok;
        i_cdb_valid = 2'b10;
        i_cdb_tag   = {4'd7, 4'd0};
        i_cdb_data  = {32'h600, 32'h0};
        dispatch(1'b0, 2'd2, 1'b0, 4'd2, 32'd8, 1'b0, 32'd0, 4'd7, 1'b0, 32'd0, 4'd0);
        i_cdb_valid = 2'b00;
        wait_req(ok);
        checks++; if (!ok || o_mem_addr !== 32'h608) begin errors++;
            $display("FAIL cdb_disp_addr: req %b addr %h want 1 00000608", ok, o_mem_addr); end
        mem_complete(32'h42);
        checks++; if (o_res_tag !== 4'd2 || o_res_data !== 32'h42) begin errors++;
            $display("FAIL cdb_disp_res: tag %0d data %h want 2 00000042", o_res_tag, o_res_data); end
    endtask

    task automatic test_fill_wrap();
        bit ok;
        for (int i = 0; i < 8; i++) begin
            dispatch(1'b0, 2'd2, 1'b0, 4'(i), 32'(4 * i), 1'b0, 32'd0, 4'd15, 1'b0, 32'd0, 4'd0);
            if (i == 6) begin
                checks++; if (o_disp_ready !== 1'b1) begin errors++;
                    $display("FAIL fill_seven_ready: got %b want 1", o_disp_ready); end
            end
        end
        checks++; if (o_disp_ready !== 1'b0) begin errors++;
            $display("FAIL fill_full: disp_ready %b want 0", o_disp_ready); end
        dispatch(1'b0, 2'd2, 1'b0, 4'd9, 32'd0, 1'b1, 32'h9990, 4'd0, 1'b0, 32'd0, 4'd0);
        i_cdb_valid = 2'b01;
        i_cdb_tag   = {4'd0, 4'd15};
        i_cdb_data  = {32'h0, 32'h3000};
        tick();
        i_cdb_valid = 2'b00;
        for (int k = 0; k < 8; k++) begin
            wait_req(ok);
            checks++; if (!ok || o_mem_addr !== 32'h3000 + 32'(4 * k)) begin errors++;
                $display("FAIL fill_addr_%0d: req %b addr %h want %h", k, ok, o_mem_addr,
                         32'h3000 + 32'(4 * k)); end
            mem_complete(32'(k));
            checks++; if (o_res_valid !== 1'b1 || o_res_tag !== 4'(k)) begin errors++;
                $display("FAIL fill_tag_%0d: v %b tag %0d want 1 %0d", k, o_res_valid, o_res_tag, k); end
            if (k == 0) begin
                checks++; if (o_disp_ready !== 1'b1) begin errors++;
                    $display("FAIL fill_pop_ready: got %b want 1", o_disp_ready); end
            end
        end
        repeat (5) tick();
        checks++; if (o_mem_req !== 1'b0) begin errors++;
            $display("FAIL fill_ninth_ignored: mem_req %b want 0", o_mem_req); end
        for (int i = 0; i < 20; i++) begin
            dispatch(1'b0, 2'd2, 1'b0, 4'(i), 32'(i), 1'b1, 32'h1000 + 32'(16 * i), 4'd0,
                     1'b0, 32'd0, 4'd0);
            wait_req(ok);
            checks++; if (!ok || o_mem_addr !== 32'h1000 + 32'(17 * i)) begin errors++;
                $display("FAIL wrap_addr_%0d: req %b addr %h want %h", i, ok, o_mem_addr,
                         32'h1000 + 32'(17 * i)); end
            mem_complete(32'hA5000000 + 32'(i));
            checks++; if (o_res_tag !== 4'(i) || o_res_data !== 32'hA5000000 + 32'(i)) begin
                errors++;
                $display("FAIL wrap_res_%0d: tag %0d data %h want %0d %h", i, o_res_tag,
                         o_res_data, i, 32'hA5000000 + 32'(i)); end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        dispatch(1'b0, 2'd2, 1'b0, 4'd1, 32'd0, 1'b1, 32'h800, 4'd0, 1'b0, 32'd0, 4'd0);
        wait_req(ok);
        set_disp(1'b0, 2'd2, 1'b0, 4'd2, 32'd0, 1'b1, 32'h840, 4'd0, 1'b0, 32'd0, 4'd0);
        i_disp_valid = 1'b1;
        mem_complete(32'h11);
        i_disp_valid = 1'b0;
        checks++; if (o_res_valid !== 1'b1 || o_res_tag !== 4'd1) begin errors++;
            $display("FAIL b2b_first: v %b tag %0d want 1 1", o_res_valid, o_res_tag); end
        wait_req(ok);
        checks++; if (!ok || o_mem_addr !== 32'h840) begin errors++;
            $display("FAIL b2b_second_addr: req %b addr %h want 1 00000840", ok, o_mem_addr); end
        mem_complete(32'h22);
        checks++; if (o_res_tag !== 4'd2 || o_res_data !== 32'h22) begin errors++;
            $display("FAIL b2b_second_res: tag %0d data %h want 2 00000022", o_res_tag, o_res_data); end
        repeat (4) tick();
        checks++; if (o_mem_req !== 1'b0) begin errors++;
            $display("FAIL b2b_empty: mem_req %b want 0", o_mem_req); end
    endtask

    task automatic test_flush_committed();
        bit ok;
        dispatch(1'b1, 2'd2, 1'b0, 4'd1, 32'd0, 1'b1, 32'h400, 4'd0, 1'b1, 32'h55, 4'd0);
        dispatch(1'b0, 2'd2, 1'b0, 4'd2, 32'd0, 1'b0, 32'd0, 4'd14, 1'b0, 32'd0, 4'd0);
        dispatch(1'b0, 2'd2, 1'b0, 4'd3, 32'd4, 1'b0, 32'd0, 4'd14, 1'b0, 32'd0, 4'd0);
        i_commit_valid = 1'b1;
        i_commit_tag   = 4'd1;
        i_flush        = 1'b1;
        tick();
        i_commit_valid = 1'b0;
        i_flush        = 1'b0;
        wait_req(ok);
        checks++; if (!ok || o_mem_we !== 1'b1 || o_mem_addr !== 32'h400) begin errors++;
            $display("FAIL flush_sw_issue: req %b we %b addr %h want 1 1 00000400", ok, o_mem_we,
                     o_mem_addr); end
        checks++; if (o_mem_wdata !== 32'h55) begin errors++;
            $display("FAIL flush_sw_data: got %h want 00000055", o_mem_wdata); end
        mem_complete(32'h0);
        i_cdb_valid = 2'b01;
        i_cdb_tag   = {4'd0, 4'd14};
        i_cdb_data  = {32'h0, 32'hB000};
        tick();
        i_cdb_valid = 2'b00;
        repeat (5) tick();
        checks++; if (o_mem_req !== 1'b0 || o_res_valid !== 1'b0) begin errors++;
            $display("FAIL flush_loads_dropped: req %b res %b want 0 0", o_mem_req, o_res_valid); end
        // Queue must now be empty: exactly 8 more dispatches fill it.
        for (int i = 0; i < 8; i++) begin
            dispatch(1'b0, 2'd2, 1'b0, 4'(i), 32'd0, 1'b0, 32'd0, 4'd13, 1'b0, 32'd0, 4'd0);
            if (i == 6) begin
                checks++; if (o_disp_ready !== 1'b1) begin errors++;
                    $display("FAIL flush_count_seven: disp_ready %b want 1", o_disp_ready); end
            end
        end
        checks++; if (o_disp_ready !== 1'b0) begin errors++;
            $display("FAIL flush_count_eight: disp_ready %b want 0", o_disp_ready); end
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        checks++; if (o_disp_ready !== 1'b1) begin errors++;
            $display("FAIL flush_all_loads: disp_ready %b want 1", o_disp_ready); end
    endtask

    task automatic test_flush_load();
        bit ok;
        bit seen;
        dispatch(1'b0, 2'd2, 1'b0, 4'd4, 32'd0, 1'b1, 32'h500, 4'd0, 1'b0, 32'd0, 4'd0);
        wait_req(ok);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        repeat (2) tick();
        checks++; if (!ok || o_mem_req !== 1'b1 || o_mem_addr !== 32'h500) begin errors++;
            $display("FAIL flush_lw_hold: req %b addr %h want 1 00000500", o_mem_req, o_mem_addr); end
        mem_complete(32'h12345678);
        seen = o_res_valid;
        checks++; if (o_mem_req !== 1'b0) begin errors++;
            $display("FAIL flush_lw_drop_req: req %b want 0", o_mem_req); end
        for (int i = 0; i < 3; i++) begin
            tick();
            seen = seen | o_res_valid;
        end
        checks++; if (seen !== 1'b0) begin errors++;
            $display("FAIL flush_lw_no_result: res_valid seen %b want 0", seen); end
        dispatch(1'b0, 2'd2, 1'b0, 4'd5, 32'd0, 1'b1, 32'h510, 4'd0, 1'b0, 32'd0, 4'd0);
        wait_req(ok);
        checks++; if (!ok || o_mem_addr !== 32'h510) begin errors++;
            $display("FAIL flush_lw_next_addr: req %b addr %h want 1 00000510", ok, o_mem_addr); end
        mem_complete(32'h77);
        checks++; if (o_res_tag !== 4'd5 || o_res_data !== 32'h77) begin errors++;
            $display("FAIL flush_lw_next_res: tag %0d data %h want 5 00000077", o_res_tag, o_res_data); end
    endtask

    task automatic test_rdy_hold();
        bit ok;
        i_rdy = 1'b0;
        dispatch(1'b0, 2'd2, 1'b0, 4'd3, 32'd0, 1'b1, 32'h900, 4'd0, 1'b0, 32'd0, 4'd0);
        i_rdy = 1'b1;
        repeat (4) tick();
        checks++; if (o_mem_req !== 1'b0) begin errors++;
            $display("FAIL rdy_disp_gated: mem_req %b want 0", o_mem_req); end
        dispatch(1'b0, 2'd2, 1'b0, 4'd3, 32'd0, 1'b1, 32'h910, 4'd0, 1'b0, 32'd0, 4'd0);
        wait_req(ok);
        i_rdy = 1'b0;
        mem_complete(32'h99);
        tick();
        checks++; if (o_mem_req !== 1'b1 || o_res_valid !== 1'b0) begin errors++;
            $display("FAIL rdy_hold: req %b res %b want 1 0", o_mem_req, o_res_valid); end
        i_rdy = 1'b1;
        mem_complete(32'h9A);
        checks++; if (!ok || o_res_valid !== 1'b1 || o_res_data !== 32'h9A) begin errors++;
            $display("FAIL rdy_resume: v %b data %h want 1 0000009a", o_res_valid, o_res_data); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        dispatch(1'b0, 2'd2, 1'b0, 4'd7, 32'd0, 1'b1, 32'hA00, 4'd0, 1'b0, 32'd0, 4'd0);
        wait_req(ok);
        rst = 1'b1;
        tick();
        checks++; if (!ok || o_mem_req !== 1'b0 || o_disp_ready !== 1'b1) begin errors++;
            $display("FAIL reset_mid: req %b ready %b want 0 1", o_mem_req, o_disp_ready); end
        rst = 1'b0;
        repeat (4) tick();
        checks++; if (o_mem_req !== 1'b0) begin errors++;
            $display("FAIL reset_mid_empty: req %b want 0", o_mem_req); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_word();
        test_extension();
        test_store_wait();
        test_cdb_dispatch();
        test_fill_wrap();
        test_back_to_back();
        test_flush_committed();
        test_flush_load();
        test_rdy_hold();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsb_queue.md
# lsb_queue

Parametrised in-order load/store queue between the dispatcher, the result buses and the memory controller. Successor to the single-bus LSB: configurable depth and tag width, snooping on CDB_CH result buses, in-order memory issue with speculative loads, commit-gated stores, and a flush that keeps already-committed stores. It returns load results to the ROB/CDB and drives one memory request at a time.

## Interface
- DEPTH, 8, entries; power of two, ≥2
- TAG_W, 4, ROB tag width
- CDB_CH, 2, number of result broadcast channels snooped
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  clock enable; rdy=0 holds all state and outputs
- flush  in  1  mispredict flush
- disp_valid  in  1  dispatch request
- disp_ready  out  1  count<DEPTH (combinational)
- disp_is_store  in  1  1=store, 0=load
- disp_size  in  2  0 byte, 1 half, 2 word
- disp_signed  in  1  sign-extend load result
- disp_tag  in  TAG_W  ROB tag of the instruction
- disp_imm  in  32  offset
- disp_base_rdy / disp_base_val / disp_base_q  in  1/32/TAG_W  base operand, value or producer tag
- disp_data_rdy / disp_data_val / disp_data_q  in  1/32/TAG_W  store data operand (ignored for loads)
- cdb_valid  in  CDB_CH  per-channel valid
- cdb_tag  in  CDB_CH*TAG_W  packed tags, channel 0 in LSBs
- cdb_data  in  CDB_CH*32  packed values
- commit_valid / commit_tag  in  1/TAG_W  ROB head commit
- mem_req  out  1  request, held until mem_done
- mem_we  out  1  1=store
- mem_addr  out  32  byte address
- mem_wdata  out  32  store data, low bytes meaningful
- mem_size  out  2  as disp_size
- mem_done  in  1  one-cycle completion pulse
- mem_rdata  in  32  raw load data, low bytes meaningful
- res_valid / res_tag / res_data  out  1/TAG_W/32  load result, one-cycle pulse

## Operation
- Circular queue: head, tail (log2 DEPTH bits, wrap naturally), count (log2 DEPTH+1 bits); all DEPTH entries usable.
- Entry: is_store, size, signed, tag, imm, base rdy/val/q, data rdy/val/q, committed.
- Dispatch when disp_valid && disp_ready && !flush: write at tail, tail+1. An operand not ready whose q matches a valid CDB channel this cycle is captured as ready.
- Snoop: every entry operand with rdy=0 and q equal to any valid cdb_tag captures that data; if several channels match, lowest index wins.
- Commit: commit_valid sets committed on the valid store entry with matching tag; loads ignore commit.
- FSM IDLE/LOAD/STORE/DRAIN. IDLE: head valid, base ready and (load, or store with data ready and committed) -> assert mem_req, addr=base+imm mod 2^32, size, we, wdata; go LOAD/STORE. LOAD + mem_done: res_valid=1, res_tag=head tag, res_data=extended mem_rdata; pop; IDLE. STORE + mem_done: pop; IDLE; no result. DRAIN + mem_done: pop nothing, no result; IDLE.
- Extension: byte/half with signed=1 sign-extend bit 7/15, else zero-extend; word unchanged.
- Flush: drop all uncommitted entries (committed stores are always a head-side prefix); tail=head+committed_count, count=committed_count. Flush in LOAD -> DRAIN (request completes, result suppressed; the load entry is dropped). Flush in STORE -> stays STORE (store is committed).
- Own load results return via one external CDB channel; no internal loopback.

## Timing
- Reset: all outputs 0 except disp_ready=1; count=0, head=tail=0, state IDLE, all entries invalid. rst mid-transaction: mem_req=0 the next cycle; memory controller is reset together.
- Dispatched entry eligible for issue from the next cycle; mem_req asserts one cycle after eligibility at head (registered).
- mem_req, mem_addr, mem_we, mem_wdata, mem_size stable while mem_req=1; mem_req drops the cycle after mem_done; next request earliest the following cycle.
- res_valid the cycle after mem_done, for exactly one cycle.
- Dispatch and pop in the same cycle: count unchanged. Dispatch when full: ignored.
- Commit and flush in the same cycle: commit applied first; that store survives.
- Flush and dispatch in the same cycle: dispatch dropped.
- CDB broadcast and dispatch with a matching q in the same cycle: captured.

## Test plan
- Reset, then dispatch LW base ready 0x100, imm 4; mem_done with rdata 0xDEADBEEF -> mem_addr=0x104, mem_we=0, res_data=0xDEADBEEF, res_tag=disp_tag.
- LB, signed, rdata 0x80 -> 0xFFFFFF80; LBU -> 0x00000080; LH signed with rdata 0x8001 -> 0xFFFF8001.
- SW, data waiting on tag 3: no mem_req until cdb_tag=3 and commit; then mem_we=1 and mem_wdata equals the captured value.
- Fill DEPTH=8 entries -> disp_ready=0 and a 9th dispatch is ignored; pop one -> disp_ready=1; exercise wrap-around over 20 ops.
- Committed SW at head, two loads behind it, flush -> SW issues, loads are dropped, count=0 afterward.
- Flush during an outstanding LW -> mem_req held until mem_done, and res_valid stays 0.
